// File: rtl/leiwand_rv32_dpram.sv
// -----------------------------------------------------------------------------
// leiwand_rv32_dpram
// Dual-port on-chip RAM for the leiwand_rv32 core.
//   Port A : read-only instruction fetch port (always full-word accesses).
//   Port B : read/write data port with 1/2/4(/8)-byte lane writes.
// Both ports use the pipelined cyc/stb/stall/ack bus. Each port accepts one
// request per cycle, and every accepted request gets exactly one ack or err
// one cycle later. After reset the block sits in INIT (both ports stalled).
// With INIT_ZERO=1 it clears one word per cycle. With INIT_ZERO=0 it waits a
// single cycle. It then moves to RUN for good.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_a_cyc/i_a_stb/i_a_addr    port A request
//   o_a_dat/o_a_ack/o_a_err     port A response (registered, dat=0 unless ack)
//   o_a_stall                   port A stall (high during INIT)
//   i_b_cyc/i_b_stb/i_b_we      port B request qualifiers
//   i_b_addr/i_b_dat/i_b_size   port B address, right-aligned data, size (bytes)
//   o_b_dat/o_b_ack/o_b_err     port B response (registered, dat=0 unless read ack)
//   o_b_stall                   port B stall (high during INIT)
// -----------------------------------------------------------------------------
module leiwand_rv32_dpram #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 1024,
    parameter int ADDR_WIDTH = 32,
    parameter int INIT_ZERO  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_a_cyc,
    input  logic                  i_a_stb,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    output logic [DATA_WIDTH-1:0] o_a_dat,
    output logic                  o_a_ack,
    output logic                  o_a_err,
    output logic                  o_a_stall,
    input  logic                  i_b_cyc,
    input  logic                  i_b_stb,
    input  logic                  i_b_we,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_dat,
    input  logic [3:0]            i_b_size,
    output logic [DATA_WIDTH-1:0] o_b_dat,
    output logic                  o_b_ack,
    output logic                  o_b_err,
    output logic                  o_b_stall
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(LANES);
    localparam int IW    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int HI    = LB + IW;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Legal access sizes: 1, 2, 4 and, for a 64-bit word, 8 bytes.
    function automatic logic size_ok(input logic [3:0] size);
        logic ok;
        case (size)
            4'd1, 4'd2, 4'd4: ok = 1'b1;
            4'd8:             ok = (DATA_WIDTH == 64);
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Natural alignment for power-of-two sizes: offset bits below size must be 0.
    function automatic logic aligned(input logic [3:0] lane_off, input logic [3:0] size);
        return (lane_off & (size - 4'd1)) == 4'd0;
    endfunction

    // Address must not carry bits above the word index and must hit a real word.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr[ADDR_WIDTH-1:HI] == {(ADDR_WIDTH-HI){1'b0}}) &&
               (32'(addr[HI-1:LB]) < MEM_SIZE);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  r_stall;
    logic                  w_stall_nxt;
    logic [IW-1:0]         r_init_cnt;
    logic                  w_init_wr;

    logic                  w_a_req;
    logic                  w_a_ok;
    logic [IW-1:0]         w_a_idx;
    logic                  r_a_ack;
    logic                  r_a_err;
    logic [DATA_WIDTH-1:0] r_a_dat;

    logic                  w_b_req;
    logic                  w_b_ok;
    logic                  w_b_wr;
    logic [IW-1:0]         w_b_idx;
    logic [LB-1:0]         w_b_off;
    logic [15:0]           w_b_size_mask;
    logic [LANES-1:0]      w_b_be;
    logic [DATA_WIDTH-1:0] w_b_wdat;
    logic                  r_b_ack;
    logic                  r_b_err;
    logic [DATA_WIDTH-1:0] r_b_dat;

    // Request decode for both ports.
    assign w_a_req = i_a_cyc & i_a_stb & ~r_stall;
    assign w_a_idx = i_a_addr[HI-1:LB];
    assign w_a_ok  = (i_a_addr[LB-1:0] == {LB{1'b0}}) && in_range(i_a_addr);

    assign w_b_req = i_b_cyc & i_b_stb & ~r_stall;
    assign w_b_idx = i_b_addr[HI-1:LB];
    assign w_b_off = i_b_addr[LB-1:0];
    assign w_b_ok  = size_ok(i_b_size) && aligned(4'(w_b_off), i_b_size) && in_range(i_b_addr);
    assign w_b_wr  = w_b_req & w_b_ok & i_b_we;

    // Lane mask covers [offset, offset+size); write data is moved up to the offset.
    assign w_b_size_mask = (16'd1 << i_b_size) - 16'd1;
    assign w_b_be        = LANES'(w_b_size_mask << w_b_off);
    assign w_b_wdat      = i_b_dat << {w_b_off, 3'b000};

    assign w_init_wr = (r_state == ST_INIT) && (INIT_ZERO != 0) && i_rst_n;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic: leave INIT after the last word is cleared (or at once).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: begin
                if ((INIT_ZERO == 0) || (r_init_cnt == IW'(MEM_SIZE - 1))) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // FSM output logic: stall is computed from the next state so it can be registered.
    always_comb begin
        w_stall_nxt = 1'b1;
        case (w_state_nxt)
            ST_INIT: w_stall_nxt = 1'b1;
            ST_RUN:  w_stall_nxt = 1'b0;
            default: w_stall_nxt = 1'b1;
        endcase
    end

    // Registered stall shared by both ports.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall <= 1'b1;
        end else begin
            r_stall <= w_stall_nxt;
        end
    end

    // Init sweep word counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_init_cnt <= {IW{1'b0}};
        end else if (w_init_wr) begin
            r_init_cnt <= r_init_cnt + IW'(1);
        end else begin
            r_init_cnt <= r_init_cnt;
        end
    end

    // Memory array: the init sweep clears one word per cycle, port B writes enabled lanes.
    always_ff @(posedge i_clk) begin
        if (w_init_wr) begin
            r_mem[r_init_cnt] <= {DATA_WIDTH{1'b0}};
        end else if (w_b_wr) begin
            for (int l = 0; l < LANES; l++) begin
                if (w_b_be[l]) begin
                    r_mem[w_b_idx][8*l +: 8] <= w_b_wdat[8*l +: 8];
                end
            end
        end
    end

    // Port A response; reads sample the array before this edge's write lands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_ack <= 1'b0;
            r_a_err <= 1'b0;
            r_a_dat <= {DATA_WIDTH{1'b0}};
        end else begin
            r_a_ack <= w_a_req & w_a_ok;
            r_a_err <= w_a_req & ~w_a_ok;
            r_a_dat <= (w_a_req & w_a_ok) ? r_mem[w_a_idx] : {DATA_WIDTH{1'b0}};
        end
    end

    // Port B response; only reads return data, writes and errors return zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_b_ack <= 1'b0;
            r_b_err <= 1'b0;
            r_b_dat <= {DATA_WIDTH{1'b0}};
        end else begin
            r_b_ack <= w_b_req & w_b_ok;
            r_b_err <= w_b_req & ~w_b_ok;
            r_b_dat <= (w_b_req & w_b_ok & ~i_b_we) ? r_mem[w_b_idx] : {DATA_WIDTH{1'b0}};
        end
    end

    assign o_a_dat   = r_a_dat;
    assign o_a_ack   = r_a_ack;
    assign o_a_err   = r_a_err;
    assign o_a_stall = r_stall;
    assign o_b_dat   = r_b_dat;
    assign o_b_ack   = r_b_ack;
    assign o_b_err   = r_b_err;
    assign o_b_stall = r_stall;

endmodule
